// File: rtl/cpu_defs.sv
// Opcode/funct constants and fetch-state encoding shared by the fetch stage
// and Control_Unit.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    VALID = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC: pc+4, or pc+4+(sext(imm)<<2) when the branch is taken.
// Arithmetic wraps silently modulo 2^ADDR_W.
module instr_fetch_next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [15:0]       imm_i,
  input  logic              take_branch_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_offset;

  assign seq_pc    = pc_i + PC_STEP;
  // Word offset: sign-extend the 16-bit immediate, then scale by 4.
  assign br_offset = {{(ADDR_W-18){imm_i[15]}}, imm_i, 2'b00};
  assign next_pc_o = take_branch_i ? (seq_pc + br_offset) : seq_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches from instruction memory via req/ack and
// presents the held word and its fields to decode via valid/ready.
module instr_fetch
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        func,
  output logic [15:0]       imm
);

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] next_pc;
  logic              take_branch;

  assign take_branch = branch_taken && (instr_q[31:26] == OP_BEQ);

  instr_fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_i          (pc_q),
    .imm_i         (instr_q[15:0]),
    .take_branch_i (take_branch),
    .next_pc_o     (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = {next_pc[ADDR_W-1:2], 2'b00};
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr = {pc_q[ADDR_W-1:2], 2'b00};
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign func      = instr_q[5:0];
  assign imm       = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetched words go into a scoreboard queue
// and are checked when instr_valid appears; the PC is tracked independently.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic [15:0] imm;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_exp_t;

  fetch_exp_t  exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] held_word;

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .pc           (pc),
    .instr        (instr),
    .op           (op),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .func         (func),
    .imm          (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc, input logic [31:0] word, input bit br);
    logic [31:0] ofs;
    ofs = {{14{word[15]}}, word[15:0], 2'b00};
    if (br && word[31:26] == 6'b000100) return cur_pc + 32'd4 + ofs;
    return cur_pc + 32'd4;
  endfunction

  // Entered at a negedge while in FETCH; returns at the negedge where the word is held.
  task automatic fetch_word(input logic [31:0] word, input int waits);
    fetch_exp_t e;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    for (int w = 0; w < waits; w++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back('{pc: exp_pc, word: word});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_set", {31'd0, instr_valid}, 32'd1);
    check("valid_req", {31'd0, imem_req}, 32'd0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("instr", instr, e.word);
      check("held_pc", pc, e.pc);
      held_word = e.word;
    end
  endtask

  // Optional stall (with stray acks that must be ignored), then consume.
  task automatic consume(input bit br, input int stall);
    for (int s = 0; s < stall; s++) begin
      instr_ready  = 1'b0;
      branch_taken = 1'b1;
      imem_ack     = 1'b1;
      imem_rdata   = $urandom;
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_instr", instr, held_word);
      check("stall_pc", pc, exp_pc);
    end
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    branch_taken = br;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    exp_pc = model_next_pc(exp_pc, held_word, br);
    check("next_req", {31'd0, imem_req}, 32'd1);
    check("next_valid", {31'd0, instr_valid}, 32'd0);
    check("next_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst          = 1'b1;
    imem_rdata   = 32'h0;
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    exp_pc       = 32'h0;
    held_word    = 32'h0;

    // Reset and release
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);

    // Zero-wait R-type: add $1,$2,$3
    fetch_word(32'h0043_0820, 0);
    check("add_op", {26'd0, op}, 32'd0);
    check("add_func", {26'd0, func}, 32'h20);
    check("add_rs", {27'd0, rs}, 32'd2);
    check("add_rt", {27'd0, rt}, 32'd3);
    check("add_rd", {27'd0, rd}, 32'd1);
    consume(1'b0, 0);
    check("add_next", imem_addr, 32'h4);

    // Wait states with junk rdata
    fetch_word(32'h8C41_0008, 3);
    consume(1'b0, 0);
    // beq not taken, then unknown opcode with branch_taken ignored
    fetch_word(32'h1000_0010, 1);
    consume(1'b0, 0);
    fetch_word(32'hFC00_1234, 0);
    check("unk_op", {26'd0, op}, 32'h3F);
    check("unk_imm", {16'd0, imm}, 32'h1234);
    consume(1'b1, 0);
    check("unk_next", imem_addr, 32'h10);

    // beq taken at 0x10, imm=-4
    fetch_word(32'h1022_FFFC, 0);
    consume(1'b1, 0);
    check("beq_taken", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      fetch_word(32'h0043_0820, i);
      consume(1'b0, 0);
    end
    check("back_at_10", imem_addr, 32'h10);

    // lw with the same immediate: branch_taken ignored; also a 5-cycle stall
    fetch_word(32'h8C22_FFFC, 2);
    consume(1'b1, 5);
    check("lw_next", imem_addr, 32'h14);

    // Branch backwards to 0xFFFFFFFC, then wrap on sequential fetch
    fetch_word(32'h1000_FFF9, 0);
    consume(1'b1, 0);
    check("to_top", imem_addr, 32'hFFFF_FFFC);
    fetch_word(32'h0043_0820, 0);
    consume(1'b0, 0);
    check("wrap", imem_addr, 32'h0);
    fetch_word(32'h0043_0820, 1);
    consume(1'b0, 0);

    // Asynchronous reset mid-fetch with an ack pending
    #2;
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("arst_hold_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_hold_instr", instr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_instr", instr, 32'h0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
